// File: rtl/smem_req_ctrl_if.sv
// ----------------------------------------------------------------------------
// smem_req_ctrl_if: request/response handshake bundle for smem_req_ctrl. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface smem_req_ctrl_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 11
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DWIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

`default_nettype wire

// File: rtl/smem_req_ctrl.sv
// ----------------------------------------------------------------------------
// smem_req_ctrl: BRAM request front-end with clear engine and 2-deep read FIFO. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module smem_req_ctrl #(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 11,
  parameter int                SIZE     = 2048,
  parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
  input  wire               clk,
  input  wire               rst_n,
  input  wire               clr,
  smem_req_ctrl_if.slave    bus,
  output logic              init_done,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  output logic              mem_wr,
  input  wire  [DWIDTH-1:0] mem_dout
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int            CW   = AWIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic              inflight;
  logic [1:0]        count;
  logic [DWIDTH-1:0] fifo0;
  logic [DWIDTH-1:0] fifo1;
  logic [AWIDTH-1:0] last_addr;
  logic [DWIDTH-1:0] last_din;

  logic              push;
  logic              pop;
  logic [2:0]        credit;
  logic              ready;
  logic              accept;
  logic              rd_accept;

  assign push = inflight;
  assign pop  = (count != 2'd0) && bus.rsp_ready;

  // A pop in the same cycle frees a slot, which keeps back-to-back reads at full rate.
  assign credit    = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign ready     = (state == ST_RUN) && !clr && (credit < 3'd2);
  assign accept    = bus.req_valid && ready;
  assign rd_accept = accept && !bus.req_wr;

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (count != 2'd0);
  assign bus.rsp_rdata = fifo0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_wr    = 1'b0;
    mem_addr  = last_addr;
    mem_din   = last_din;
    init_done = 1'b0;
    case (state)
      ST_INIT: begin
        // Held-low reset must not leak a write strobe onto the RAM.
        if (rst_n) begin
          mem_wr   = 1'b1;
          mem_addr = cnt[AWIDTH-1:0];
          mem_din  = INIT_VAL;
        end
        if (clr) begin
          cnt_nxt = '0;
        end else if (cnt == LAST) begin
          cnt_nxt   = '0;
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_RUN: begin
        init_done = 1'b1;
        if (accept) begin
          mem_wr   = bus.req_wr;
          mem_addr = bus.req_addr;
          mem_din  = bus.req_wdata;
        end
        if (clr) begin
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      inflight  <= 1'b0;
      count     <= 2'd0;
      fifo0     <= '0;
      fifo1     <= '0;
      last_addr <= '0;
      last_din  <= '0;
    end else begin
      cnt       <= cnt_nxt;
      inflight  <= rd_accept;
      last_addr <= mem_addr;
      last_din  <= mem_din;
      // fifo0 is the registered head; fifo1 only ever holds the second entry.
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            fifo0 <= mem_dout;
          end else begin
            fifo1 <= mem_dout;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          fifo0 <= fifo1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            fifo0 <= mem_dout;
          end else begin
            fifo0 <= fifo1;
            fifo1 <= mem_dout;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_smem_req_ctrl.sv
// ----------------------------------------------------------------------------
// tb_smem_req_ctrl: scoreboard bench for smem_req_ctrl with a behavioural RAM. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_smem_req_ctrl;

  localparam int             DW = 32;
  localparam int             AW = 4;
  localparam int             SZ = 16;
  localparam logic [DW-1:0]  IV = 32'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  smem_req_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  logic          init_done;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  smem_req_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .SIZE(SZ), .INIT_VAL(IV)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus), .init_done(init_done),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wr(mem_wr), .mem_dout(mem_dout)
  );

  // Single-port RAM: one-cycle read latency, output held during writes.
  logic [DW-1:0] ram [SZ];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_din;
    else        mem_dout      <= ram[mem_addr];
  end

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            acc_cyc = 0;
  int            rdy_mode = 1;
  logic [DW-1:0] ref_mem [SZ];
  logic [DW-1:0] exp_q [$];
  int            rsp_cycs [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    case (rdy_mode)
      0:       bus.rsp_ready = 1'b0;
      1:       bus.rsp_ready = 1'b1;
      default: bus.rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge clk) begin
    #2;
    if (prev_hold && rst_n) check("rsp_stable", bus.rsp_rdata, prev_data);
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got %0h expected no response", bus.rsp_rdata);
      end else begin
        check("rsp_data", bus.rsp_rdata, exp_q.pop_front());
        rsp_cycs.push_back(cyc);
      end
    end
    prev_hold = rst_n && bus.rsp_valid && !bus.rsp_ready;
    prev_data = bus.rsp_rdata;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic fill_ref();
    for (int i = 0; i < SZ; i++) ref_mem[i] = IV;
  endtask

  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int max_wait, output bit acc);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    acc = 1'b0;
    for (int i = 0; i < max_wait && !acc; i++) begin
      if (bus.req_ready) begin
        acc     = 1'b1;
        acc_cyc = cyc;
        if (wr) ref_mem[a] = d;
        else    exp_q.push_back(ref_mem[a]);
      end
      step();
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc;
    issue(wr, a, d, 60, acc);
    check("req_accept", acc, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
    step();
    check("drain", exp_q.size(), 0);
  endtask

  task automatic init_seq();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("init_rsp_idle", bus.rsp_valid, 0);
    for (int i = 0; i < SZ; i++) begin
      check("init_cycle", {mem_wr, init_done, mem_addr, mem_din}, {1'b1, 1'b0, AW'(i), IV});
      step();
    end
    check("init_done_rise", {init_done, mem_wr}, 2'b10);
    fill_ref();
  endtask

  task automatic wait_rsp_valid();
    for (int i = 0; i < 10 && !bus.rsp_valid; i++) step();
    check("rsp_valid_seen", bus.rsp_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int first, n;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    fill_ref();
    repeat (3) step();
    check("rst_values", {bus.req_ready, bus.rsp_valid, init_done, mem_wr, mem_addr, mem_din}, '0);
    check("rst_rdata", bus.rsp_rdata, 0);
    init_seq();

    // Cleared array reads back init value; then write/read latency.
    req(1'b0, 4'd5, '0);
    drain();
    req(1'b1, 4'd3, 32'hDEADBEEF);
    req(1'b0, 4'd3, '0);
    first = acc_cyc;
    for (int i = 0; i < 10 && !bus.rsp_valid; i++) step();
    check("rd_latency", cyc - first, 2);
    drain();

    // Back-to-back reads at full rate.
    for (int i = 0; i < 8; i++) req(1'b1, AW'(i), 32'h100 + i);
    rsp_cycs.delete();
    req(1'b0, 4'd0, '0);
    first = acc_cyc;
    for (int i = 1; i < 8; i++) req(1'b0, AW'(i), '0);
    check("b2b_accept_span", acc_cyc - first, 7);
    drain();
    check("b2b_rsp_count", rsp_cycs.size(), 8);
    if (rsp_cycs.size() == 8) check("b2b_rsp_span", rsp_cycs[7] - rsp_cycs[0], 7);

    // Backpressure: two credits only.
    rdy_mode = 0;
    step();
    rsp_cycs.delete();
    req(1'b0, 4'd0, '0);
    req(1'b0, 4'd1, '0);
    issue(1'b0, 4'd2, '0, 6, acc);
    check("credit_stall", acc, 0);
    check("fifo_head", {bus.rsp_valid, bus.rsp_rdata}, {1'b1, 32'h100});
    rdy_mode = 1;
    for (int i = 2; i < 8; i++) req(1'b0, AW'(i), '0);
    drain();
    check("bp_rsp_count", rsp_cycs.size(), 8);

    // Alternating read/write: reads respond, writes do not.
    rsp_cycs.delete();
    for (int i = 0; i < 8; i++) begin
      req(1'b0, 4'd1, '0);
      req(1'b1, 4'd2, $urandom);
    end
    req(1'b0, 4'd2, '0);
    drain();
    check("alt_rsp_count", rsp_cycs.size(), 9);

    // clr with one FIFO entry pending and one read in flight.
    rdy_mode = 0;
    step();
    req(1'b0, 4'd4, '0);
    wait_rsp_valid();
    req(1'b0, 4'd6, '0);
    clr = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 4'd0;
    check("clr_blocks_req", bus.req_ready, 0);
    step();
    clr = 1'b0;
    bus.req_valid = 1'b0;
    fill_ref();
    rdy_mode = 1;
    check("clr_init_start", {init_done, mem_wr, mem_addr}, {1'b0, 1'b1, AW'(0)});
    n = 0;
    for (int i = 0; i < SZ + 10 && !init_done; i++) begin
      n++;
      step();
    end
    check("clr_init_len", n, SZ);
    check("clr_pending_drained", exp_q.size(), 0);
    for (int i = 0; i < SZ; i++) req(1'b0, AW'(i), '0);
    drain();

    // Reset in the middle of a re-clear discards buffered data.
    rdy_mode = 0;
    step();
    req(1'b0, 4'd9, '0);
    wait_rsp_valid();
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid", {bus.rsp_valid, bus.req_ready, mem_wr, init_done}, 4'b0);
    rdy_mode = 1;
    step();
    init_seq();

    // Randomised traffic with random response backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 80; i++) req(1'($urandom_range(0, 1)), AW'($urandom_range(0, SZ - 1)), $urandom);
    rdy_mode = 1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
